// File: rtl/led_pkg.sv
// Shared constants and FSM state type for the LED pixel serializer and the driver side.
package led_pkg;
    localparam int PIXEL_W      = 16;
    localparam int FRAME_PIXELS = 512;
    localparam int PIX_IDX_W    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;
endpackage

// File: rtl/led_piso_shift.sv
// Parallel-load, LSB-first shift register; serial out is the register LSB itself.
// Shifting zeros in means the output drops to 0 once all bits have gone out.
module led_piso_shift #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             sout_o
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (load_i) begin
            sr_d = din_i;
        end else if (shift_i) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sout_o = sr_q[0];
endmodule

// File: rtl/led_pixel_serializer.sv
// Bit-serial pixel feeder: each accepted pixel goes out LSB first on DAI with DEN high, then a DEN-low gap.
// First bit one DCK after accept; pix_ready only in IDLE or the last gap cycle, never during frame_restart.
module led_pixel_serializer #(
    parameter int PIXEL_W      = led_pkg::PIXEL_W,
    parameter int FRAME_PIXELS = led_pkg::FRAME_PIXELS,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                            DCK,
    input  logic                            rst,
    input  logic [PIXEL_W-1:0]              pix_data,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    input  logic                            frame_restart,
    output logic                            DAI,
    output logic                            DEN,
    output logic [$clog2(FRAME_PIXELS)-1:0] pix_index,
    output logic                            frame_done,
    output logic                            busy
);
    import led_pkg::*;

    localparam int BIT_W = $clog2(PIXEL_W);
    localparam int IDX_W = $clog2(FRAME_PIXELS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PIXEL_W - 1);
    localparam logic [3:0]       LAST_GAP = 4'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_PIX = IDX_W'(FRAME_PIXELS - 1);

    state_e           state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [IDX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [IDX_W-1:0] pix_index_q, pix_index_d;
    logic             den_q, den_d;
    logic             frame_done_q, frame_done_d;
    logic             sr_load, sr_shift, sr_clr;
    logic             gap_last;
    logic             accept;

    assign gap_last  = (state_q == GAP) && (gap_cnt_q == LAST_GAP);
    assign pix_ready = !rst && !frame_restart && ((state_q == IDLE) || gap_last);
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        pix_index_d  = pix_index_q;
        den_d        = den_q;
        frame_done_d = 1'b0;
        sr_load      = 1'b0;
        sr_shift     = 1'b0;
        sr_clr       = 1'b0;

        if (frame_restart) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            gap_cnt_d   = '0;
            pix_cnt_d   = '0;
            pix_index_d = '0;
            den_d       = 1'b0;
            sr_clr      = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d     = SHIFT;
                        bit_cnt_d   = '0;
                        den_d       = 1'b1;
                        sr_load     = 1'b1;
                        pix_index_d = pix_cnt_q;
                    end
                end
                SHIFT: begin
                    sr_shift = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d   = GAP;
                        den_d     = 1'b0;
                        gap_cnt_d = '0;
                        pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        // pix_index_q still names the pixel whose gap is ending
                        frame_done_d = (pix_index_q == LAST_PIX);
                        if (accept) begin
                            state_d     = SHIFT;
                            bit_cnt_d   = '0;
                            den_d       = 1'b1;
                            sr_load     = 1'b1;
                            pix_index_d = pix_cnt_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    den_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge DCK) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            pix_cnt_q    <= '0;
            pix_index_q  <= '0;
            den_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_index_q  <= pix_index_d;
            den_q        <= den_d;
            frame_done_q <= frame_done_d;
        end
    end

    led_piso_shift #(
        .WIDTH (PIXEL_W)
    ) u_shift (
        .clk_i   (DCK),
        .rst_i   (rst),
        .clr_i   (sr_clr),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .din_i   (pix_data),
        .sout_o  (DAI)
    );

    assign DEN        = den_q;
    assign pix_index  = pix_index_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == SHIFT) || (state_q == GAP);
endmodule

// File: doc/led_pixel_serializer.md
Name: led_pixel_serializer

Overview:
Upstream feeder for the LED display driver. Accepts 16-bit grey-level pixels on a valid/ready handshake and emits them bit-serially on DAI/DEN, LSB first, 16 bits per pixel. After each pixel it holds DEN low so the driver commits the word to its frame buffer. It counts 512 pixels per frame, pulses frame_done after the last one, and sits between the host pixel source and the display driver's DCK-domain input.

Parameters:
PIXEL_W, 16, bits per pixel; also the DEN-high burst length.
FRAME_PIXELS, 512, pixels per frame (32 scanlines x 16 columns).
GAP_CYCLES, 2, DEN-low cycles after each pixel; legal range 1..15.

Ports:
DCK  input  1  data clock; all logic on posedge. Same clock the driver samples DAI/DEN on.
rst  input  1  reset, synchronous, active-high.
pix_data  input  PIXEL_W  pixel grey level.
pix_valid  input  1  pix_data valid.
pix_ready  output  1  serializer can accept a pixel this cycle.
frame_restart  input  1  synchronous abort; next accepted pixel is pixel 0 of a new frame.
DAI  output  1  serial data to driver, registered.
DEN  output  1  serial enable to driver, registered.
pix_index  output  9  index of pixel currently or last shifted, 0..511.
frame_done  output  1  one-cycle pulse after the last DEN-low gap of pixel 511.
busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset (rst=1 at posedge): state IDLE, DAI=0, DEN=0, pix_ready=0 during reset cycle then 1, pix_index=0, frame_done=0, busy=0, bit and gap counters 0, pixel counter 0.
- IDLE: pix_ready=1. On pix_valid&pix_ready, load shift register with pix_data and go to SHIFT. At the next edge DEN=1 and DAI=pix_data[0]. This is a 1-cycle latency from the accept edge to the first bit.
- SHIFT: 16 cycles with DEN=1. In cycle k (0..15) DAI=pix_data[k]. After bit 15, go to GAP.
- GAP: DEN=0, DAI=0 for GAP_CYCLES cycles. pix_ready=1 only in the last GAP cycle.
  - An accept in that cycle goes straight to SHIFT, giving back-to-back pixels.
  - Otherwise the block goes to IDLE. DEN stays low in IDLE.
  - Minimum pixel period is 16+GAP_CYCLES cycles.
- pix_index: takes the accepted pixel's index on accept. The pixel counter increments modulo FRAME_PIXELS at the end of SHIFT.
- frame_done: pulses for 1 cycle on the edge leaving GAP when the finished pixel had index FRAME_PIXELS-1. The pixel counter wraps to 0 and serialization continues.
- frame_restart (sampled on DCK edge):
  - Forces IDLE, DEN=0, DAI=0, and clears pixel, bit and gap counters. pix_index=0.
  - An in-flight pixel is truncated; no frame_done is generated.
  - It has priority over an accept in the same cycle. The accept does not happen and pix_ready is 0 while frame_restart=1.
- rst has priority over everything. rst mid-SHIFT drops DEN at the reset edge.
- pix_data is captured only on accept. Changes to pix_data while not accepting are ignored.
- DEN and DAI never glitch: both come straight from flops.

Decomposition:
- Package led_pkg holds:
  - PIXEL_W=16, FRAME_PIXELS=512, PIX_IDX_W=9.
  - State enum {IDLE, SHIFT, GAP}.
  - The driver sides also import it.
- Sub-module led_piso_shift: 16-bit parallel-load, LSB-first shift register with load/shift enables and registered serial out. The top holds the FSM and counters.

Test Plan:
- Reset then single pixel 0xA5C3, GAP_CYCLES=2 -> accept at cycle 0. DEN=1 cycles 1-16. DAI sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. DEN=0 cycles 17-18. pix_ready=1 at cycle 18. pix_index=0.
- pix_valid held high with 3 pixels 0x0001, 0x8000, 0xFFFF -> back-to-back, period 18 cycles. DAI high only at bit 0 / bit 15 / all 16 bits respectively. pix_index 0,1,2.
- Stream 512 pixels of value i -> frame_done single pulse after pixel 511's gap. Pixel 512 gets pix_index=0. A reference model of the driver's frame buffer matches all 512 words.
- frame_restart asserted at bit 7 of pixel 5 -> DEN=0 next edge. Next accepted pixel gets pix_index=0. No frame_done.
- rst asserted mid-SHIFT, with pix_valid=1 in same cycle as frame_restart -> reset values at the rst edge. No accept occurs in the restart cycle.
- pix_valid toggled randomly (50%) for 1000 pixels -> no pixel dropped or duplicated. DEN high runs are exactly 16 cycles, low runs at least GAP_CYCLES.
